// File: rtl/key_led_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : key_led_ctrl_if
// Brief    : Key edge-status in, LED drive and display mode out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface key_led_ctrl_if #(
  parameter int LED_W = 4
);
  logic [1:0]       key_status;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;

  modport master (output key_status, input led, input mode);
  modport slave  (input key_status, output led, output mode);
endinterface

`default_nettype wire

// File: rtl/key_led_ctrl.sv
//------------------------------------------------------------------------------
// Module   : key_led_ctrl
// Brief    : Key press/release/long-press decode driving OFF/ON/BLINK/RUN LEDs.
//            Define LED_ACTIVE_LOW_EN for active-low LED pins.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_led_ctrl #(
  parameter int LED_W    = 4,
  parameter int TICK_CNT = 25000000,
  parameter int LONG_CNT = 50000000
) (
  input  wire             sys_clk,
  input  wire             sys_rst,
  key_led_ctrl_if.slave   bus
);

  localparam int TICK_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam int HOLD_W = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;

  localparam logic [TICK_W-1:0] c_TICK_MAX = TICK_W'(TICK_CNT - 1);
  localparam logic [HOLD_W-1:0] c_HOLD_MAX = HOLD_W'(LONG_CNT - 1);
  localparam logic [LED_W-1:0]  c_RUN_INIT = LED_W'(1);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0]  c_POL = '1;
`else
  localparam logic [LED_W-1:0]  c_POL = '0;
`endif

  localparam logic [1:0] c_M_OFF   = 2'd0;
  localparam logic [1:0] c_M_ON    = 2'd1;
  localparam logic [1:0] c_M_BLINK = 2'd2;
  localparam logic [1:0] c_M_RUN   = 2'd3;

  typedef enum logic [1:0] {
    K_UP   = 2'd0,
    K_DOWN = 2'd1,
    K_LONG = 2'd2
  } key_state_t;

  key_state_t        r_state;
  logic [1:0]        r_evt_prev;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [1:0]        r_mode;
  logic              r_mode_chg;
  logic [LED_W-1:0]  r_led;

  logic              w_press;
  logic              w_release;
  logic              w_short;
  logic              w_long;
  logic [1:0]        w_mode_next;
  logic              w_mode_chg;
  logic              w_tick;
  logic [LED_W-1:0]  w_pat_cur;
  logic [LED_W-1:0]  w_pat_next;

  always_comb begin
    w_press     = (bus.key_status == 2'd2) && (r_evt_prev != 2'd2);
    w_release   = (bus.key_status == 2'd1) && (r_evt_prev != 2'd1);
    // A release on the threshold cycle takes priority over the long press.
    w_short     = (r_state == K_DOWN) && w_release;
    w_long      = (r_state == K_DOWN) && !w_release && (r_hold_cnt == c_HOLD_MAX);
    w_mode_next = r_mode;
    if (w_long)
      w_mode_next = c_M_OFF;
    else if (w_short)
      w_mode_next = r_mode + 2'd1;
    w_mode_chg  = (w_mode_next != r_mode);
    w_tick      = (r_tick_cnt == c_TICK_MAX);
  end

  // The LED register holds pin polarity; patterns are computed active-high.
  always_comb begin
    w_pat_cur  = r_led ^ c_POL;
    w_pat_next = w_pat_cur;
    case (r_mode)
      c_M_OFF:   w_pat_next = '0;
      c_M_ON:    w_pat_next = '1;
      c_M_BLINK: begin
        if (r_mode_chg)
          w_pat_next = '1;
        else if (w_tick)
          w_pat_next = ~w_pat_cur;
      end
      c_M_RUN: begin
        if (r_mode_chg)
          w_pat_next = c_RUN_INIT;
        else if (w_tick)
          w_pat_next = {w_pat_cur[LED_W-2:0], w_pat_cur[LED_W-1]};
      end
      default:   w_pat_next = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state    <= K_UP;
      r_evt_prev <= 2'd0;
      r_hold_cnt <= '0;
      r_tick_cnt <= '0;
      r_mode     <= c_M_OFF;
      r_mode_chg <= 1'b0;
      r_led      <= c_POL;
    end else begin
      r_evt_prev <= bus.key_status;

      case (r_state)
        K_UP: begin
          if (w_press) begin
            r_state    <= K_DOWN;
            r_hold_cnt <= '0;
          end
        end
        K_DOWN: begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
          if (w_release)
            r_state <= K_UP;
          else if (w_long)
            r_state <= K_LONG;
        end
        K_LONG: begin
          if (w_release)
            r_state <= K_UP;
        end
        default: r_state <= K_UP;
      endcase

      r_mode     <= w_mode_next;
      r_mode_chg <= w_mode_chg;

      if (w_mode_chg || w_tick)
        r_tick_cnt <= '0;
      else
        r_tick_cnt <= r_tick_cnt + 1'b1;

      r_led <= w_pat_next ^ c_POL;
    end
  end

  assign bus.led  = r_led;
  assign bus.mode = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_key_led_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_key_led_ctrl
// Brief    : Directed stimulus with a cycle-level reference model for key_led_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_led_ctrl;

  localparam int LED_W    = 4;
  localparam int TICK_CNT = 4;
  localparam int LONG_CNT = 10;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0] c_POL = '1;
`else
  localparam logic [LED_W-1:0] c_POL = '0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cmp_en  = 1'b0;

  key_led_ctrl_if #(.LED_W(LED_W)) bus ();

  key_led_ctrl #(
    .LED_W    (LED_W),
    .TICK_CNT (TICK_CNT),
    .LONG_CNT (LONG_CNT)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode from press/release rules, LEDs from age since mode entry.
  int               m_mode = 0;
  int               m_age  = 0;
  logic [1:0]       m_prev = 2'd0;
  bit               m_down = 1'b0;
  bit               m_long = 1'b0;
  int               m_hold = 0;
  logic [LED_W-1:0] m_led  = c_POL;

  function automatic logic [LED_W-1:0] led_of(input int md, input int age);
    int steps;
    steps = age / TICK_CNT;
    case (md)
      0:       led_of = '0;
      1:       led_of = '1;
      2:       led_of = (steps % 2 == 0) ? '1 : '0;
      default: led_of = LED_W'(1) << (steps % LED_W);
    endcase
  endfunction

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      m_mode = 0; m_age = 0; m_prev = 2'd0;
      m_down = 1'b0; m_long = 1'b0; m_hold = 0;
      m_led  = c_POL;
    end else begin
      int  nm;
      bit  prs, rel;
      logic [1:0] ks;
      ks  = bus.key_status;
      prs = (ks == 2'd2) && (m_prev != 2'd2);
      rel = (ks == 2'd1) && (m_prev != 2'd1);
      nm  = m_mode;
      m_led = led_of(m_mode, m_age + 1) ^ c_POL;
      if (m_down) begin
        if (m_long) begin
          if (rel) begin m_down = 1'b0; m_long = 1'b0; end
        end else begin
          m_hold++;
          if (rel) begin
            m_down = 1'b0;
            nm = (m_mode + 1) % 4;
          end else if (m_hold == LONG_CNT) begin
            m_long = 1'b1;
            nm = 0;
          end
        end
      end else if (prs) begin
        m_down = 1'b1; m_long = 1'b0; m_hold = 0;
      end
      m_age  = (nm != m_mode) ? 0 : m_age + 1;
      m_mode = nm;
      m_prev = ks;
    end
  end

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      check("model_mode", 32'(bus.mode), 32'(m_mode));
      check("model_led",  32'(bus.led),  32'(m_led));
    end
  end

  task automatic send(input logic [1:0] code, input int n);
    bus.key_status = code;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic short_press();
    send(2'd2, 1); send(2'd0, 3); send(2'd1, 1); send(2'd0, 1);
  endtask

  initial begin
    bus.key_status = 2'd0;
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    cmp_en  = 1'b1;
    check("reset_mode", 32'(bus.mode), 32'd0);
    check("reset_led",  32'(bus.led),  32'(4'b0000 ^ c_POL));
    send(2'd0, 2);

    // Short presses walk OFF->ON->BLINK with the blink timing checked.
    short_press();
    check("short1_mode", 32'(bus.mode), 32'd1);
    check("short1_led",  32'(bus.led),  32'(4'b1111 ^ c_POL));
    short_press();
    check("blink_mode",  32'(bus.mode), 32'd2);
    check("blink_entry", 32'(bus.led),  32'(4'b1111 ^ c_POL));
    send(2'd0, 3);
    check("blink_t4",    32'(bus.led),  32'(4'b0000 ^ c_POL));
    send(2'd0, 4);
    check("blink_t8",    32'(bus.led),  32'(4'b1111 ^ c_POL));

    short_press();
    check("run_mode",    32'(bus.mode), 32'd3);
    check("run_0",       32'(bus.led),  32'(4'b0001 ^ c_POL));
    send(2'd0, 3);
    check("run_1",       32'(bus.led),  32'(4'b0010 ^ c_POL));
    send(2'd0, 4);
    check("run_2",       32'(bus.led),  32'(4'b0100 ^ c_POL));
    send(2'd0, 4);
    check("run_3",       32'(bus.led),  32'(4'b1000 ^ c_POL));
    send(2'd0, 4);
    check("run_wrap",    32'(bus.led),  32'(4'b0001 ^ c_POL));

    short_press();
    check("wrap_mode",   32'(bus.mode), 32'd0);
    check("wrap_led",    32'(bus.led),  32'(4'b0000 ^ c_POL));

    // Long press from RUN.
    short_press(); short_press(); short_press();
    check("pre_long_mode", 32'(bus.mode), 32'd3);
    send(2'd2, 1);
    send(2'd0, 9);
    check("long_hold9",  32'(bus.mode), 32'd3);
    send(2'd0, 1);
    check("long_hold10", 32'(bus.mode), 32'd0);
    send(2'd0, 2);
    send(2'd1, 1);
    send(2'd0, 2);
    check("long_release", 32'(bus.mode), 32'd0);

    // Held and ignored codes.
    send(2'd2, 5); send(2'd3, 1); send(2'd1, 5); send(2'd0, 2);
    check("held_once",   32'(bus.mode), 32'd1);
    send(2'd3, 3); send(2'd0, 2);
    check("code3_none",  32'(bus.mode), 32'd1);
    check("code3_led",   32'(bus.led),  32'(4'b1111 ^ c_POL));

    // Asynchronous reset between clock edges.
    #2 sys_rst = 1'b0;
    #1;
    check("async_rst_mode", 32'(bus.mode), 32'd0);
    check("async_rst_led",  32'(bus.led),  32'(4'b0000 ^ c_POL));
    @(negedge sys_clk);
    sys_rst = 1'b1;
    send(2'd0, 2);
    short_press();
    check("post_rst_mode", 32'(bus.mode), 32'd1);
    send(2'd0, 3);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
